// File: rtl/parity_mem_if.sv
// Access bus for parity_mem: read/write strobes, address and payload going in,
// read data and its status pulses coming back.
interface parity_mem_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) ();
   logic              write;
   logic              read;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic              inject_err;
   logic [DATA_W:0]   data_out;
   logic              rd_valid;
   logic              parity_err;

   modport master (
      output write, read, address, data_in, inject_err,
      input  data_out, rd_valid, parity_err
   );

   modport slave (
      input  write, read, address, data_in, inject_err,
      output data_out, rd_valid, parity_err
   );
endinterface

// File: rtl/parity_mem.sv
// Single-port memory storing {even parity, data} per word, with a scrub engine
// that sweeps every location, counting parity failures and remembering the
// address of the first one seen since reset.
module parity_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   parity_mem_if.slave       bus,
   input  logic              scrub_start,
   output logic              illegal_op,
   output logic              busy,
   output logic              scrub_done,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_vld,
   output logic [CNT_W-1:0]  error_count
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, SCRUB, DONE} state_t;

   state_t            state;
   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W-1:0] scrub_addr;
   logic              scrub_tail;

   logic              do_write;
   logic              do_read;
   logic              do_illegal;
   logic              do_scrub_rd;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W:0]   rd_word;
   logic              rd_fail;
   logic [1:0]        err_inc;
   logic [CNT_W:0]    cnt_sum;

   // Decode this cycle's action; host strobes only count in IDLE and lose to scrub_start.
   always_comb begin
      do_write   = 1'b0;
      do_read    = 1'b0;
      do_illegal = 1'b0;
      if (rst_n && state == IDLE && !scrub_start) begin
         do_write   = bus.write & ~bus.read;
         do_read    = bus.read & ~bus.write;
         do_illegal = bus.write & bus.read;
      end
      do_scrub_rd = rst_n && (state == SCRUB) && !scrub_tail;
      rd_addr     = do_scrub_rd ? scrub_addr : bus.address;
      rd_word     = mem[rd_addr];
      rd_fail     = (do_read | do_scrub_rd) & (^rd_word);
      err_inc     = {1'b0, rd_fail} + {1'b0, do_illegal};
      cnt_sum     = {1'b0, error_count} + (CNT_W+1)'(err_inc);
   end

   // Storage array; contents survive reset, parity is generated on the way in.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[bus.address] <= {(^bus.data_in) ^ bus.inject_err, bus.data_in};
      end
   end

   // Control FSM plus all registered outputs, read check and error bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         scrub_addr     <= '0;
         scrub_tail     <= 1'b0;
         bus.data_out   <= '0;
         bus.rd_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
         illegal_op     <= 1'b0;
         busy           <= 1'b0;
         scrub_done     <= 1'b0;
         first_err_addr <= '0;
         first_err_vld  <= 1'b0;
         error_count    <= '0;
      end else begin
         bus.rd_valid   <= do_read | do_scrub_rd;
         bus.parity_err <= rd_fail;
         illegal_op     <= do_illegal;
         scrub_done     <= 1'b0;
         if (do_read || do_scrub_rd) begin
            bus.data_out <= rd_word;
         end
         if (err_inc != 2'd0) begin
            error_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
         end
         if (rd_fail && !first_err_vld) begin
            first_err_vld  <= 1'b1;
            first_err_addr <= rd_addr;
         end
         case (state)
            IDLE: begin
               if (scrub_start) begin
                  state      <= SCRUB;
                  busy       <= 1'b1;
                  scrub_addr <= '0;
                  scrub_tail <= 1'b0;
               end
            end
            SCRUB: begin
               if (scrub_tail) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  scrub_done <= 1'b1;
               end else begin
                  scrub_addr <= scrub_addr + ADDR_W'(1);
                  if (scrub_addr == '1) begin
                     scrub_tail <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_parity_mem.sv
// Bench for parity_mem: a wide instance for host read/write behaviour and a
// small instance (16 words, 2-bit counter) for scrub, reset-abort and saturation.
module tb_parity_mem;
   logic clk = 1'b0;
   logic rst_a, rst_b, ss_a, ss_b;
   logic ill_a, busy_a, done_a, fvld_a;
   logic ill_b, busy_b, done_b, fvld_b;
   logic [7:0]  faddr_a;
   logic [3:0]  faddr_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   int n_checks = 0;
   int n_pass = 0;

   parity_mem_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
   parity_mem_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

   parity_mem #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_a), .bus(bus_a), .scrub_start(ss_a),
      .illegal_op(ill_a), .busy(busy_a), .scrub_done(done_a),
      .first_err_addr(faddr_a), .first_err_vld(fvld_a), .error_count(cnt_a)
   );

   parity_mem #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_b), .bus(bus_b), .scrub_start(ss_b),
      .illegal_op(ill_b), .busy(busy_b), .scrub_done(done_b),
      .first_err_addr(faddr_b), .first_err_vld(fvld_b), .error_count(cnt_b)
   );

   always #5 clk = ~clk;

   // Reference model: index 0 is dut_a, index 1 is dut_b
   logic [8:0] mmem [2][256];
   int         depth [2] = '{256, 16};
   int         cmax [2] = '{65535, 3};
   logic [8:0] m_dout [2];
   logic       m_valid [2];
   logic       m_perr [2];
   logic       m_ill [2];
   logic       m_busy [2];
   logic       m_done [2];
   logic       m_fvld [2];
   int         m_faddr [2];
   int         m_cnt [2];
   int         m_scrub_t [2];
   bit         m_ready [2] = '{1'b0, 1'b0};

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_read(input int k, input int a);
      logic [8:0] word;
      word = mmem[k][a];
      m_dout[k]  = word;
      m_valid[k] = 1'b1;
      if (^word) begin
         m_perr[k] = 1'b1;
         if (!m_fvld[k]) begin
            m_fvld[k]  = 1'b1;
            m_faddr[k] = a;
         end
      end
   endtask

   // One clock edge of the spec: scrub follows a timeline counted from the start edge
   task automatic model_step(input int k, input logic rn, input logic w, input logic r,
                             input int a, input logic [7:0] d, input logic inj, input logic ss);
      int sum;
      m_valid[k] = 1'b0;
      m_perr[k]  = 1'b0;
      m_ill[k]   = 1'b0;
      m_done[k]  = 1'b0;
      if (!rn) begin
         m_dout[k] = '0; m_busy[k] = 1'b0; m_fvld[k] = 1'b0; m_faddr[k] = 0;
         m_cnt[k] = 0; m_scrub_t[k] = -1; m_ready[k] = 1'b1;
         return;
      end
      if (m_scrub_t[k] >= 0) begin
         m_scrub_t[k]++;
         if (m_scrub_t[k] <= depth[k]) model_read(k, m_scrub_t[k] - 1);
         m_busy[k] = (m_scrub_t[k] <= depth[k]);
         m_done[k] = (m_scrub_t[k] == depth[k] + 1);
         if (m_scrub_t[k] == depth[k] + 2) m_scrub_t[k] = -1;
      end else if (ss) begin
         m_scrub_t[k] = 0;
         m_busy[k] = 1'b1;
      end else if (w && r) begin
         m_ill[k] = 1'b1;
      end else if (w) begin
         mmem[k][a] = {(^d) ^ inj, d};
      end else if (r) begin
         model_read(k, a);
      end
      sum = m_cnt[k] + int'(m_perr[k]) + int'(m_ill[k]);
      m_cnt[k] = (sum > cmax[k]) ? cmax[k] : sum;
   endtask

   // Advance the model on every rising edge from the inputs the DUTs sample
   always @(posedge clk) begin
      model_step(0, rst_a, bus_a.write, bus_a.read, int'(bus_a.address), bus_a.data_in, bus_a.inject_err, ss_a);
      model_step(1, rst_b, bus_b.write, bus_b.read, int'(bus_b.address), bus_b.data_in, bus_b.inject_err, ss_b);
   end

   // Compare every output of both DUTs against the model on each falling edge
   always @(negedge clk) begin
      if (m_ready[0]) begin
         check_output("a.data_out", 32'(bus_a.data_out), 32'(m_dout[0]));
         check_output("a.rd_valid", 32'(bus_a.rd_valid), 32'(m_valid[0]));
         check_output("a.parity_err", 32'(bus_a.parity_err), 32'(m_perr[0]));
         check_output("a.illegal_op", 32'(ill_a), 32'(m_ill[0]));
         check_output("a.busy", 32'(busy_a), 32'(m_busy[0]));
         check_output("a.scrub_done", 32'(done_a), 32'(m_done[0]));
         check_output("a.first_err_addr", 32'(faddr_a), 32'(m_faddr[0]));
         check_output("a.first_err_vld", 32'(fvld_a), 32'(m_fvld[0]));
         check_output("a.error_count", 32'(cnt_a), 32'(m_cnt[0]));
      end
      if (m_ready[1]) begin
         check_output("b.data_out", 32'(bus_b.data_out), 32'(m_dout[1]));
         check_output("b.rd_valid", 32'(bus_b.rd_valid), 32'(m_valid[1]));
         check_output("b.parity_err", 32'(bus_b.parity_err), 32'(m_perr[1]));
         check_output("b.illegal_op", 32'(ill_b), 32'(m_ill[1]));
         check_output("b.busy", 32'(busy_b), 32'(m_busy[1]));
         check_output("b.scrub_done", 32'(done_b), 32'(m_done[1]));
         check_output("b.first_err_addr", 32'(faddr_b), 32'(m_faddr[1]));
         check_output("b.first_err_vld", 32'(fvld_b), 32'(m_fvld[1]));
         check_output("b.error_count", 32'(cnt_b), 32'(m_cnt[1]));
      end
   end

   // Drive one cycle of inputs on the chosen DUT, returning just after the next falling edge
   task automatic apply_stimulus(input int k, input logic w, input logic r, input int addr,
                                 input logic [7:0] d, input logic inj, input logic ss);
      if (k == 0) begin
         bus_a.write = w; bus_a.read = r; bus_a.address = 8'(addr);
         bus_a.data_in = d; bus_a.inject_err = inj; ss_a = ss;
      end else begin
         bus_b.write = w; bus_b.read = r; bus_b.address = 4'(addr);
         bus_b.data_in = d; bus_b.inject_err = inj; ss_b = ss;
      end
      @(negedge clk);
   endtask

   // Hard stop if the sequence ever stalls
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 50000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence with hand-computed expectations
   initial begin
      int wr_addr [6] = '{'h01, 'h42, 'h7E, 'h99, 'hC3, 'hF0};
      logic [7:0] wr_data [6] = '{8'h11, 8'hFF, 8'h80, 8'h6B, 8'h00, 8'h01};
      logic [8:0] wr_word [6] = '{9'h011, 9'h0FF, 9'h180, 9'h16B, 9'h000, 9'h101};
      int rd_order [6] = '{4, 2, 5, 0, 3, 1};
      int busy_cnt, perr_cnt, done_at, done_cnt;

      rst_a = 1'b0; rst_b = 1'b0; ss_a = 1'b0; ss_b = 1'b0;
      bus_a.write = 0; bus_a.read = 0; bus_a.address = '0; bus_a.data_in = '0; bus_a.inject_err = 0;
      bus_b.write = 0; bus_b.read = 0; bus_b.address = '0; bus_b.data_in = '0; bus_b.inject_err = 0;
      repeat (2) @(negedge clk);
      check_output("reset.data_out", 32'(bus_a.data_out), 32'h0);
      check_output("reset.error_count", 32'(cnt_a), 32'h0);
      check_output("reset.busy", 32'(busy_b), 32'h0);
      check_output("reset.first_err_vld", 32'(fvld_a), 32'h0);
      rst_a = 1'b1; rst_b = 1'b1;

      // Basic write then back-to-back reads
      apply_stimulus(0, 1, 0, 'h10, 8'hA5, 0, 0);
      apply_stimulus(0, 1, 0, 'h20, 8'h3C, 0, 0);
      apply_stimulus(0, 0, 1, 'h10, 8'h00, 0, 0);
      check_output("basic.rd0", 32'(bus_a.data_out), 32'h0A5);
      check_output("basic.valid0", 32'(bus_a.rd_valid), 32'h1);
      check_output("basic.perr0", 32'(bus_a.parity_err), 32'h0);
      apply_stimulus(0, 0, 1, 'h20, 8'h00, 0, 0);
      check_output("basic.rd1", 32'(bus_a.data_out), 32'h03C);
      check_output("basic.valid1", 32'(bus_a.rd_valid), 32'h1);
      apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0);
      check_output("basic.valid_drop", 32'(bus_a.rd_valid), 32'h0);
      check_output("basic.count", 32'(cnt_a), 32'h0);

      // Six pairs read back in shuffled order
      for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, wr_addr[i], wr_data[i], 0, 0);
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(0, 0, 1, wr_addr[rd_order[i]], 8'h00, 0, 0);
         check_output("shuffle.rd", 32'(bus_a.data_out), 32'(wr_word[rd_order[i]]));
      end
      check_output("shuffle.count", 32'(cnt_a), 32'h0);

      // Injected parity error
      apply_stimulus(0, 1, 0, 'h05, 8'h07, 1, 0);
      apply_stimulus(0, 0, 1, 'h05, 8'h00, 0, 0);
      check_output("inject.data", 32'(bus_a.data_out), 32'h007);
      check_output("inject.perr", 32'(bus_a.parity_err), 32'h1);
      check_output("inject.count", 32'(cnt_a), 32'h1);
      check_output("inject.faddr", 32'(faddr_a), 32'h05);
      check_output("inject.fvld", 32'(fvld_a), 32'h1);

      // Simultaneous strobes leave memory untouched
      apply_stimulus(0, 1, 1, 'h10, 8'hFF, 0, 0);
      check_output("illegal.pulse", 32'(ill_a), 32'h1);
      check_output("illegal.count", 32'(cnt_a), 32'h2);
      apply_stimulus(0, 0, 1, 'h10, 8'h00, 0, 0);
      check_output("illegal.mem", 32'(bus_a.data_out), 32'h0A5);
      check_output("illegal.drop", 32'(ill_a), 32'h0);

      // Second failure keeps the first address
      apply_stimulus(0, 1, 0, 'h06, 8'h01, 1, 0);
      apply_stimulus(0, 0, 1, 'h06, 8'h00, 0, 0);
      check_output("second.perr", 32'(bus_a.parity_err), 32'h1);
      check_output("second.faddr", 32'(faddr_a), 32'h05);
      check_output("second.count", 32'(cnt_a), 32'h3);
      apply_stimulus(0, 0, 0, 0, 8'h00, 0, 0);

      // Scrub on the 16-word instance with errors at 0x3 and 0xC
      for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 0, i, 8'(i * 17), (i == 3 || i == 12), 0);
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 1);
      check_output("scrub.busy_rise", 32'(busy_b), 32'h1);
      busy_cnt = 1; perr_cnt = 0; done_at = -1;
      for (int j = 2; j <= 40; j++) begin
         apply_stimulus(1, (j == 2), 0, 0, 8'hFF, 0, 0);
         if (busy_b) busy_cnt++;
         if (bus_b.parity_err) perr_cnt++;
         if (done_b) begin
            done_at = j;
            break;
         end
      end
      check_output("scrub.busy_cycles", 32'(busy_cnt), 32'd17);
      check_output("scrub.perr_pulses", 32'(perr_cnt), 32'd2);
      check_output("scrub.done_cycle", 32'(done_at), 32'd18);
      check_output("scrub.count", 32'(cnt_b), 32'h2);
      check_output("scrub.faddr", 32'(faddr_b), 32'h3);
      check_output("scrub.fvld", 32'(fvld_b), 32'h1);
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
      check_output("scrub.done_drop", 32'(done_b), 32'h0);
      apply_stimulus(1, 0, 1, 0, 8'h00, 0, 0);
      check_output("scrub.write_ignored", 32'(bus_b.data_out), 32'h000);
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);

      // Reset during a sweep aborts it and keeps memory
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 1);
      repeat (5) apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
      check_output("abort.busy_before", 32'(busy_b), 32'h1);
      rst_b = 1'b0;
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
      rst_b = 1'b1;
      check_output("abort.busy", 32'(busy_b), 32'h0);
      check_output("abort.count", 32'(cnt_b), 32'h0);
      check_output("abort.fvld", 32'(fvld_b), 32'h0);
      done_cnt = 0;
      for (int j = 0; j < 25; j++) begin
         apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
         if (done_b) done_cnt++;
      end
      check_output("abort.no_done", 32'(done_cnt), 32'd0);
      apply_stimulus(1, 0, 1, 3, 8'h00, 0, 0);
      check_output("abort.mem3", 32'(bus_b.data_out), 32'h133);
      check_output("abort.perr3", 32'(bus_b.parity_err), 32'h1);
      apply_stimulus(1, 0, 1, 12, 8'h00, 0, 0);
      check_output("abort.memC", 32'(bus_b.data_out), 32'h1CC);
      check_output("abort.count2", 32'(cnt_b), 32'h2);

      // Saturation of the 2-bit counter
      rst_b = 1'b0;
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
      rst_b = 1'b1;
      for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 1, i, 8'h00, 0, 0);
      check_output("sat.count", 32'(cnt_b), 32'h3);
      apply_stimulus(1, 0, 0, 0, 8'h00, 0, 0);
      check_output("sat.hold", 32'(cnt_b), 32'h3);
      check_output("sat.ill_drop", 32'(ill_b), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/parity_mem.md
# parity_mem

Parametrised single-port, parity-protected memory with a built-in scrub engine. Each write stores `{^data_in, data_in}` (even parity, parity bit in the MSB); each read returns the stored word and checks its parity. A scrub mode sweeps every location, counts parity failures and records the first failing address. It sits behind `my_mem_interface`-style read/write strobes and replaces the fixed 8-bit/9-bit memory.

## Interface

**Parameters**
- `DATA_W`, 8, payload width; stored word is `DATA_W+1` bits.
- `ADDR_W`, 8, address width; depth = `2**ADDR_W`.
- `CNT_W`, 16, width of `error_count`.

**Ports** (clock and reset first)
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `write` in 1: write strobe.
- `read` in 1: read strobe.
- `address` in `ADDR_W`: access address.
- `data_in` in `DATA_W`: write payload.
- `inject_err` in 1: when high with `write`, the stored parity bit is inverted (test hook).
- `scrub_start` in 1: one-cycle request to start a scrub sweep.
- `data_out` out `DATA_W+1`: `{parity, data}` of the last read.
- `rd_valid` out 1: one-cycle pulse; `data_out` is valid.
- `parity_err` out 1: one-cycle pulse, coincident with `rd_valid`, when the read word fails parity.
- `illegal_op` out 1: one-cycle pulse when `write` and `read` are sampled together.
- `busy` out 1: scrub in progress.
- `scrub_done` out 1: one-cycle pulse at the end of a sweep.
- `first_err_addr` out `ADDR_W`: address of the first parity failure since reset.
- `first_err_vld` out 1: `first_err_addr` holds a valid address.
- `error_count` out `CNT_W`: saturating count of parity failures plus illegal ops.

## Operation

- **FSM states:** IDLE, SCRUB, DONE.
- **IDLE**
  - `write` only: `mem[address] <= {^data_in ^ inject_err, data_in}`.
  - `read` only: registered read. `data_out`, `rd_valid`, and the parity check appear on the next cycle.
  - `write` and `read` together: neither is performed; `illegal_op` pulses and `error_count` increments.
  - `scrub_start` has priority over `write`/`read` in the same cycle; that access is dropped silently.
- **SCRUB**
  - `busy`=1. An internal address counter runs 0 to `2**ADDR_W-1`, reading one location per cycle.
  - Each word is checked one cycle later, as in a normal read. `parity_err` pulses per failure and `error_count` increments.
  - `rd_valid` and `data_out` also update for each scrubbed word.
  - `write`, `read` and `scrub_start` are ignored: no memory change, no `illegal_op`.
  - After the last address has been checked, go to DONE.
- **DONE:** `scrub_done`=1 and `busy`=0 for one cycle, then go to IDLE.
- **Parity check:** failure when `stored[DATA_W] != ^stored[DATA_W-1:0]`.
- **First-error capture:** on the first failure, whether from a read or a scrub, latch the address and set `first_err_vld`. Later failures do not overwrite it until reset.
- **Error counter:** saturates at `2**CNT_W-1`. If a parity failure and an illegal op land in the same cycle, it adds 2 (still saturating).
- **Reset:** clears all outputs and the FSM. Memory contents are not reset; reads of never-written locations return undefined data.
- **Reset mid-scrub:** the scrub aborts, the FSM returns to IDLE, and no `scrub_done` is issued.

## Timing

- **Reset values:** `data_out`=0, `rd_valid`=0, `parity_err`=0, `illegal_op`=0, `busy`=0, `scrub_done`=0, `first_err_addr`=0, `first_err_vld`=0, `error_count`=0.
- **Write:** data is visible to a read sampled on the next edge.
- **Read latency:** 1 cycle from the sampled `read` to `rd_valid`. Back-to-back reads give back-to-back `rd_valid`.
- **Read-after-write:**
  - Write at edge N, read of the same address at edge N+1: returns the new data.
  - Write at edge N, read of the same address at edge N: not possible (that is an illegal op).
- **`illegal_op` and its count update:** 1 cycle after sampling.
- **Scrub length:**
  - `busy` rises the cycle after `scrub_start` is sampled.
  - `scrub_done` asserts `2**ADDR_W + 1` cycles after `busy` rises.
  - Total `2**ADDR_W + 2` cycles from sample to `scrub_done`.

## Test plan

- **Write/read basic:** write 0xA5 @0x10, 0x3C @0x20, then read both → `data_out` = 0x0A5 and 0x03C, `rd_valid` 1 cycle after each `read`, `parity_err`=0, `error_count`=0.
- **Shuffled readback:** write 6 random addr/data pairs, read them in shuffled order → each `data_out` equals `{^d,d}`, `error_count`=0.
- **Inject:** write 0x07 @0x05 with `inject_err`=1, then read → `data_out`=0x007, `parity_err`=1, `error_count`=1, `first_err_addr`=0x05, `first_err_vld`=1.
- **Simultaneous strobes:** `write`=`read`=1 with `address`=0x10 → `illegal_op` pulse, `mem[0x10]` unchanged (reads 0x0A5), `error_count` +1.
- **Scrub:** `ADDR_W`=4, fill all 16 locations, inject at 0x3 and 0xC, pulse `scrub_start` → `busy` for 17 cycles, two `parity_err` pulses, `error_count`=2, `first_err_addr`=0x3, `scrub_done` 18 cycles after start; a `write` during `busy` has no effect.
- **Reset mid-scrub and saturation:**
  - `rst_n`=0 during scrub → next cycle `busy`=0, `error_count`=0, no `scrub_done`, memory retained.
  - `CNT_W`=2 with 5 illegal ops → `error_count` holds at 3.
